// File: rtl/serial_sub.sv
// serial_sub: bit-serial word subtractor, D = A - B - bin, LSB first.
// A single full-subtractor cell and a registered borrow flop process one
// bit per clock. The controlling FSM sees a start/busy/done handshake.
// Optional feature: define SERIAL_SUB_OVF_EN to add the two's-complement
// overflow output 'ovf'. The default build leaves it out.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             d_bit,
`ifdef SERIAL_SUB_OVF_EN
  output logic             d_bit_valid,
  output logic             ovf
`else
  output logic             d_bit_valid
`endif
);

  // The counter must be able to hold WIDTH itself, not just WIDTH-1.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             borrow;
  logic [CW-1:0]    count;

`ifdef SERIAL_SUB_OVF_EN
  // The operand MSBs are shifted out of a_sh/b_sh, so keep copies for ovf.
  logic             a_msb;
  logic             b_msb;
`endif

  logic             x;
  logic             y;
  logic             diff;
  logic             borrow_nxt;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] d_sh_nxt;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  always_comb begin
    x          = a_sh[0];
    y          = b_sh[0];
    diff       = x ^ y ^ borrow;
    borrow_nxt = (~x & y) | (~(x ^ y) & borrow);
    d_sh_nxt   = {diff, d_sh[WIDTH-1:1]};
    last_bit   = (count == CW'(WIDTH - 1));
    // A start in the DONE cycle is accepted the same way as one in IDLE.
    accept     = start && ((state == IDLE) || (state == DONE));
  end

  // Control FSM, operand shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      d_sh        <= '0;
      borrow      <= 1'b0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      d           <= '0;
      bo          <= 1'b0;
      d_bit       <= 1'b0;
      d_bit_valid <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      ovf         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end

        SHIFT: begin
          a_sh        <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh        <= {1'b0, b_sh[WIDTH-1:1]};
          d_sh        <= d_sh_nxt;
          borrow      <= borrow_nxt;
          count       <= count + CW'(1);
          d_bit       <= diff;
          d_bit_valid <= 1'b1;
          if (last_bit) begin
            d     <= d_sh_nxt;
            bo    <= borrow_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_msb ^ b_msb) & (diff ^ a_msb);
`endif
          end
        end

        DONE: begin
          done        <= 1'b0;
          d_bit_valid <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Loading the operands overrides the IDLE/DONE defaults above.
      if (accept) begin
        a_sh        <= a;
        b_sh        <= b;
        d_sh        <= '0;
        borrow      <= bin;
        count       <= '0;
        busy        <= 1'b1;
        d_bit_valid <= 1'b0;
        state       <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
        a_msb       <= a[WIDTH-1];
        b_msb       <= b[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed, table-driven self-checking bench for serial_sub
// with WIDTH=8. It also exercises ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             d_bit;
  logic             d_bit_valid;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int n_checks;
  int n_fail;
  logic [WIDTH-1:0] prev_d;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] exp_d;
    logic             exp_bo;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[9];

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .busy        (busy),
    .done        (done),
    .d           (d),
    .bo          (bo),
    .d_bit       (d_bit),
`ifdef SERIAL_SUB_OVF_EN
    .d_bit_valid (d_bit_valid),
    .ovf         (ovf)
`else
    .d_bit_valid (d_bit_valid)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the operands and start. Then follow the serial stream up to the
  // completion edge, which leaves the DUT in its DONE cycle.
  task automatic applyStimulus(input vec_t v);
    a     = v.a;
    b     = v.b;
    bin   = v.bin;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~v.a;
    b     = ~v.b;
    bin   = ~v.bin;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    checkOutput("done_after_start", {31'd0, done}, 32'd0);
    checkOutput("dbv_after_start", {31'd0, d_bit_valid}, 32'd0);
    for (int k = 1; k <= WIDTH; k++) begin
      tick();
      checkOutput("d_bit_valid", {31'd0, d_bit_valid}, 32'd1);
      checkOutput("d_bit", {31'd0, d_bit}, {31'd0, v.exp_d[k-1]});
      if (k < WIDTH) begin
        checkOutput("done_early", {31'd0, done}, 32'd0);
        checkOutput("d_held", {24'd0, d}, {24'd0, prev_d});
      end
    end
    checkOutput("done_final", {31'd0, done}, 32'd1);
    checkOutput("busy_final", {31'd0, busy}, 32'd0);
    checkOutput("d_final", {24'd0, d}, {24'd0, v.exp_d});
    checkOutput("bo_final", {31'd0, bo}, {31'd0, v.exp_bo});
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("ovf_final", {31'd0, ovf}, {31'd0, v.exp_ovf});
`endif
    prev_d = v.exp_d;
  endtask

  // Leave the DONE cycle without a new start and confirm the result holds.
  task automatic finishIdle(input vec_t v);
    tick();
    checkOutput("done_fall", {31'd0, done}, 32'd0);
    checkOutput("dbv_fall", {31'd0, d_bit_valid}, 32'd0);
    checkOutput("busy_idle", {31'd0, busy}, 32'd0);
    checkOutput("d_hold_idle", {24'd0, d}, {24'd0, v.exp_d});
    checkOutput("bo_hold_idle", {31'd0, bo}, {31'd0, v.exp_bo});
  endtask

  initial begin
    vec_t v;
    int   done_count;

    n_checks = 0;
    n_fail   = 0;
    prev_d   = '0;

    //          a       b      bin   d      bo    ovf
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_d", {24'd0, d}, 32'd0);
    checkOutput("rst_bo", {31'd0, bo}, 32'd0);
    checkOutput("rst_d_bit", {31'd0, d_bit}, 32'd0);
    checkOutput("rst_dbv", {31'd0, d_bit_valid}, 32'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    a     = 8'h05;
    b     = 8'h03;
    tick();
    checkOutput("rst_vs_start_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    tick();
    checkOutput("idle_no_busy", {31'd0, busy}, 32'd0);

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      finishIdle(vecs[i]);
    end

    $display("[TB] start while busy is ignored");
    a     = 8'h10;
    b     = 8'h01;
    bin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a     = 8'h55;
    b     = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = '0;
    b     = '0;
    checkOutput("busy_ignore", {31'd0, busy}, 32'd1);
    done_count = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) begin
        done_count++;
        checkOutput("ignore_d", {24'd0, d}, 32'h0F);
        checkOutput("ignore_bo", {31'd0, bo}, 32'd0);
      end
    end
    checkOutput("ignore_done_count", done_count, 32'd1);
    checkOutput("ignore_d_hold", {24'd0, d}, 32'h0F);
    prev_d = 8'h0F;

    $display("[TB] reset mid-operation");
    a     = 8'h05;
    b     = 8'h03;
    bin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    checkOutput("midrst_d", {24'd0, d}, 32'd0);
    checkOutput("midrst_dbv", {31'd0, d_bit_valid}, 32'd0);
    done_count = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) done_count++;
    end
    checkOutput("midrst_no_done", done_count, 32'd0);
    prev_d = '0;
    applyStimulus(vecs[1]);
    finishIdle(vecs[1]);

    $display("[TB] start accepted in DONE cycle");
    applyStimulus(vecs[0]);
    v = '{8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0};
    applyStimulus(v);
    finishIdle(v);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
